pwm_ramp_ctrl: RTL and testbench

Sequencer that sits in front of the pwm block and drives its 7-bit duty_cycle input. Upstream logic (e.g. the motor/command FSM) issues target duty values over a valid/ready handshake. The controller ramps duty_cycle toward each target in 1% steps at a programmable rate, which avoids current spikes on the driven load. An emergency-stop input overrides all targets.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_step_timer.sv | 37 +++
 rtl/pwm_ramp_ctrl.sv | 143 ++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: duty width, default duty clamp and ramp controller states.
package pwm_pkg;

   localparam int DUTY_W           = 7;
   localparam int MAX_DUTY_DEFAULT = 100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      STOP = 2'd2
   } state_e;

   function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] req,
                                                    input logic [DUTY_W-1:0] lim);
      return (req > lim) ? lim : req;
   endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Step cadence counter: emits a one-cycle step every STEP_TICKS enables; clear restarts the count.
module pwm_step_timer #(
   parameter int STEP_TICKS = 1000,
   parameter int CNT_W      = 10
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic step
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_TICKS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      step  = enable && !clear && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (clear || step) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps the pwm duty_cycle toward handshaked targets in 1% steps with emergency stop.
// Optional SOFT_STOP_EN: estop ramps duty down one step per one_MHz_enable instead of zeroing it.
module pwm_ramp_ctrl
   import pwm_pkg::*;
#(
   parameter int MAX_DUTY   = MAX_DUTY_DEFAULT,
   parameter int STEP_TICKS = 1000,
   parameter int CNT_W      = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              one_MHz_enable,
   input  logic [DUTY_W-1:0] target_duty,
   input  logic              target_valid,
   output logic              target_ready,
   input  logic              estop,
   output logic [DUTY_W-1:0] duty_cycle,
   output logic              ramping,
   output logic              done,
   output logic              clamped
);

   localparam logic [DUTY_W-1:0] MAX_D = DUTY_W'(MAX_DUTY);

   state_e            state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [DUTY_W-1:0] target_q, target_d;
   logic              ramping_q, ramping_d;
   logic              done_q, done_d;
   logic              clamped_q, clamped_d;

   logic              accept;
   logic [DUTY_W-1:0] acc_tgt;
   logic [DUTY_W-1:0] tgt_eff;
   logic              clear_cnt;
   logic              step;

   assign target_ready = (state_q != STOP) && !estop;
   assign accept       = target_valid && target_ready;
   assign acc_tgt      = clamp_duty(target_duty, MAX_D);

   pwm_step_timer #(
      .STEP_TICKS (STEP_TICKS),
      .CNT_W      (CNT_W)
   ) u_step_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  ((state_q == RAMP) && one_MHz_enable),
      .clear   (clear_cnt),
      .step    (step)
   );

   always_comb begin
      state_d   = state_q;
      duty_d    = duty_q;
      target_d  = target_q;
      done_d    = 1'b0;
      clamped_d = 1'b0;
      clear_cnt = 1'b0;
      tgt_eff   = target_q;

      if (state_q == STOP) begin
         clear_cnt = 1'b1;
`ifdef SOFT_STOP_EN
         if (one_MHz_enable && (duty_q != '0)) begin
            duty_d = duty_q - DUTY_W'(1);
         end
         if (!estop && (duty_q == '0)) begin
            state_d = IDLE;
         end
`else
         if (!estop) begin
            state_d = IDLE;
         end
`endif
      end else if (estop) begin
         state_d   = STOP;
         target_d  = '0;
         clear_cnt = 1'b1;
`ifndef SOFT_STOP_EN
         duty_d    = '0;
`endif
      end else begin
         if (accept) begin
            target_d  = acc_tgt;
            tgt_eff   = acc_tgt;
            clamped_d = (target_duty > MAX_D);
         end
         if (state_q == IDLE) begin
            if (accept) begin
               if (acc_tgt != duty_q) begin
                  state_d   = RAMP;
                  clear_cnt = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end else begin
            // A retarget keeps the running step count; the step moves toward the newest target.
            if (tgt_eff == duty_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (step) begin
               duty_d = (tgt_eff > duty_q) ? duty_q + DUTY_W'(1) : duty_q - DUTY_W'(1);
               if (duty_d == tgt_eff) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
      end

`ifdef SOFT_STOP_EN
      ramping_d = (state_d == RAMP) || ((state_d == STOP) && (duty_d != '0));
`else
      ramping_d = (state_d == RAMP);
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         duty_q    <= '0;
         target_q  <= '0;
         ramping_q <= 1'b0;
         done_q    <= 1'b0;
         clamped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         duty_q    <= duty_d;
         target_q  <= target_d;
         ramping_q <= ramping_d;
         done_q    <= done_d;
         clamped_q <= clamped_d;
      end
   end

   assign duty_cycle = duty_q;
   assign ramping    = ramping_q;
   assign done       = done_q;
   assign clamped    = clamped_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed scenarios plus random traffic vs a behavioural model.
module tb_pwm_ramp_ctrl;

   localparam int STEP_TICKS = 2;
   localparam int CNT_W      = 2;
   localparam int MAX_DUTY   = 100;
   localparam int M_IDLE = 0, M_RAMP = 1, M_STOP = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       one_MHz_enable = 1'b0;
   logic [6:0] target_duty = '0;
   logic       target_valid = 1'b0;
   logic       estop = 1'b0;
   logic       target_ready;
   logic [6:0] duty_cycle;
   logic       ramping, done, clamped;

   pwm_ramp_ctrl #(
      .MAX_DUTY   (MAX_DUTY),
      .STEP_TICKS (STEP_TICKS),
      .CNT_W      (CNT_W)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .one_MHz_enable (one_MHz_enable),
      .target_duty    (target_duty),
      .target_valid   (target_valid),
      .target_ready   (target_ready),
      .estop          (estop),
      .duty_cycle     (duty_cycle),
      .ramping        (ramping),
      .done           (done),
      .clamped        (clamped)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int done_cnt = 0;
   int max_duty_seen = 0;

   // Behavioural model: mode, duty percent, target percent, enables counted in the current step.
   int m_mode = M_IDLE;
   int m_duty = 0;
   int m_tgt = 0;
   int m_ticks = 0;
   bit m_done = 0;
   bit m_clamped = 0;

   task automatic model_update(input bit acc, input int td, input bit es, input bit en);
      bit stepn;
      int old_duty;
      m_done    = 0;
      m_clamped = 0;
      old_duty  = m_duty;
`ifdef SOFT_STOP_EN
      if (m_mode == M_STOP) begin
         if (en && m_duty > 0) m_duty = m_duty - 1;
         if (!es && old_duty == 0) m_mode = M_IDLE;
      end else if (es) begin
         m_mode = M_STOP; m_tgt = 0; m_ticks = 0;
      end else begin
`else
      if (es) begin
         m_mode = M_STOP; m_duty = 0; m_tgt = 0; m_ticks = 0;
      end else if (m_mode == M_STOP) begin
         m_mode = M_IDLE;
      end else begin
`endif
         stepn = 0;
         if (m_mode == M_RAMP && en) begin
            m_ticks = (m_ticks + 1) % STEP_TICKS;
            stepn   = (m_ticks == 0);
         end
         if (acc) begin
            m_tgt     = (td > MAX_DUTY) ? MAX_DUTY : td;
            m_clamped = (td > MAX_DUTY);
         end
         if (m_mode == M_IDLE) begin
            if (acc) begin
               if (m_tgt != m_duty) begin
                  m_mode = M_RAMP; m_ticks = 0;
               end else begin
                  m_done = 1;
               end
            end
         end else if (m_tgt == m_duty) begin
            m_mode = M_IDLE; m_done = 1;
         end else if (stepn) begin
            m_duty = m_duty + ((m_tgt > m_duty) ? 1 : -1);
            if (m_duty == m_tgt) begin
               m_mode = M_IDLE; m_done = 1;
            end
         end
      end
   endtask

   // One clock: drive inputs, check target_ready, advance model at the edge, check registered outputs.
   task automatic drive_cycle(input bit v, input int td, input bit es);
      bit en, exp_ready, exp_ramping;
      en             = (cyc % 4 == 3);
      target_valid   = v;
      target_duty    = 7'(td);
      estop          = es;
      one_MHz_enable = en;
      #1;
      exp_ready = (m_mode != M_STOP) && !es;
      tests++;
      if (target_ready !== exp_ready) begin
         fails++;
         $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, target_ready, exp_ready);
      end
      @(posedge clk);
      model_update(v && exp_ready, td, es, en);
      #1;
`ifdef SOFT_STOP_EN
      exp_ramping = (m_mode == M_RAMP) || (m_mode == M_STOP && m_duty != 0);
`else
      exp_ramping = (m_mode == M_RAMP);
`endif
      tests++;
      if (duty_cycle !== 7'(m_duty)) begin
         fails++;
         $display("FAIL duty cyc=%0d got=%0d exp=%0d", cyc, duty_cycle, m_duty);
      end
      tests++;
      if (ramping !== exp_ramping || done !== m_done || clamped !== m_clamped) begin
         fails++;
         $display("FAIL flags cyc=%0d ramping/done/clamped got=%b%b%b exp=%b%b%b",
                  cyc, ramping, done, clamped, exp_ramping, m_done, m_clamped);
      end
      if (done === 1'b1) done_cnt++;
      if (int'(duty_cycle) > max_duty_seen) max_duty_seen = int'(duty_cycle);
      cyc++;
   endtask

   task automatic run_until_done(input int budget, input string name);
      int n = 0;
      while (!m_done && n < budget) begin
         drive_cycle(0, 0, 0);
         n++;
      end
      tests++;
      if (done !== 1'b1) begin
         fails++;
         $display("FAIL %s done_timeout got done=%b after %0d cycles", name, done, n);
      end
   endtask

   task automatic run_until_duty(input int d, input int budget, input string name);
      int n = 0;
      while (m_duty != d && n < budget) begin
         drive_cycle(0, 0, 0);
         n++;
      end
      tests++;
      if (duty_cycle !== 7'(d)) begin
         fails++;
         $display("FAIL %s reach_duty got=%0d exp=%0d", name, duty_cycle, d);
      end
   endtask

   task automatic test_reset();
      #22;
      tests++;
      if (duty_cycle !== 7'd0 || ramping !== 1'b0 || done !== 1'b0 || clamped !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs got duty=%0d r/d/c=%b%b%b exp 0 000", duty_cycle, ramping, done, clamped);
      end
      reset_n = 1'b1;
      #1;
      tests++;
      if (target_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready got=%b exp=1", target_ready);
      end
      repeat (3) drive_cycle(0, 0, 0);
   endtask

   task automatic test_ramp_up();
      done_cnt = 0;
      drive_cycle(1, 5, 0);
      run_until_done(200, "ramp_up");
      repeat (6) drive_cycle(0, 0, 0);
      tests++;
      if (duty_cycle !== 7'd5 || done_cnt != 1) begin
         fails++;
         $display("FAIL ramp_up_final got duty=%0d done_pulses=%0d exp 5 1", duty_cycle, done_cnt);
      end
   endtask

   task automatic test_clamp();
      max_duty_seen = 0;
      drive_cycle(1, 120, 0);
      tests++;
      if (clamped !== 1'b1) begin
         fails++;
         $display("FAIL clamp_pulse got=%b exp=1", clamped);
      end
      run_until_done(2000, "clamp");
      repeat (10) drive_cycle(0, 0, 0);
      tests++;
      if (duty_cycle !== 7'd100 || max_duty_seen != 100) begin
         fails++;
         $display("FAIL clamp_limit got duty=%0d max=%0d exp 100 100", duty_cycle, max_duty_seen);
      end
   endtask

   task automatic test_retarget();
      drive_cycle(0, 0, 1);
      run_until_duty(0, 400, "retarget_zero");
      drive_cycle(0, 0, 0);
      drive_cycle(0, 0, 0);
      drive_cycle(1, 10, 0);
      run_until_duty(6, 200, "retarget_mid");
      done_cnt = 0;
      drive_cycle(1, 3, 0);
      run_until_done(200, "retarget");
      repeat (6) drive_cycle(0, 0, 0);
      tests++;
      if (duty_cycle !== 7'd3 || done_cnt != 1) begin
         fails++;
         $display("FAIL retarget_final got duty=%0d done_pulses=%0d exp 3 1", duty_cycle, done_cnt);
      end
   endtask

   task automatic test_estop();
      drive_cycle(1, 20, 0);
      run_until_duty(7, 200, "estop_mid");
      done_cnt = 0;
      drive_cycle(1, 50, 1);
`ifndef SOFT_STOP_EN
      tests++;
      if (duty_cycle !== 7'd0 || ramping !== 1'b0) begin
         fails++;
         $display("FAIL estop_zero got duty=%0d ramping=%b exp 0 0", duty_cycle, ramping);
      end
      repeat (3) drive_cycle(1, 50, 1);
`else
      for (int n = 0; n < 60 && m_duty != 0; n++) drive_cycle(1, 50, 1);
      drive_cycle(0, 0, 1);
`endif
      repeat (8) drive_cycle(0, 0, 0);
      tests++;
      if (duty_cycle !== 7'd0 || done_cnt != 0 || target_ready !== 1'b1) begin
         fails++;
         $display("FAIL estop_release got duty=%0d done_pulses=%0d ready=%b exp 0 0 1",
                  duty_cycle, done_cnt, target_ready);
      end
   endtask

   task automatic test_random();
      bit v, es;
      int td;
      for (int i = 0; i < 600; i++) begin
         v  = ($urandom_range(0, 5) == 0);
         td = ($urandom_range(0, 3) == 0) ? int'($urandom_range(95, 127)) : int'($urandom_range(0, 20));
         es = ($urandom_range(0, 60) == 0);
         drive_cycle(v, td, es);
      end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_clamp();
      test_retarget();
      test_estop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
